mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Load/store stage directly downstream of the ex stage.
- Takes a decoded memory request (address, size, store data, destination register) from ex and runs it on a req/gnt/rvalid data bus.
- Returns formatted load data to the register file write port.
- Drives hold_flag_o toward ctrl so the pipeline freezes while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT for bus_rvalid_i before the access is aborted with a bus-timeout exception.
- TO_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on rising clk)
- req_i  in  1  ex presents a load/store this cycle
- we_i  in  1  1=store, 0=load
- size_i  in  3  funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2
- addr_i  in  32  byte address (rs1+imm from ex)
- wdata_i  in  32  store data (rs2)
- rd_addr_i  in  5  load destination register
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-replicated store data
- bus_gnt_i  in  1  request accepted
- bus_rvalid_i  in  1  response valid (load data or store ack)
- bus_rdata_i  in  32  load data word
- rd_addr_o  out  5  writeback register
- rd_data_o  out  32  writeback data
- rd_wr_en_o  out  1  one-cycle writeback pulse
- hold_flag_o  out  1  stall request to ctrl
- exc_o  out  1  one-cycle exception pulse
- exc_cause_o  out  2  1=misaligned, 2=bus timeout, 3=illegal size; 0 otherwise

Behaviour:
- Reset (rst==0): state=IDLE; all outputs 0; timeout counter 0. Reset mid-access drops bus_req_o at that edge; no writeback and no exception are produced for the aborted access.
- States: IDLE, REQ, WAIT.
- IDLE, req_i=1, illegal size (load 3/6/7; store >=3): exc_o=1 and cause=3 next cycle; stay IDLE; no bus activity.
- IDLE, req_i=1, misaligned (half with addr[0]=1; word with addr[1:0]!=0): exc_o=1 and cause=1 next cycle; stay IDLE; no bus activity.
- IDLE, req_i=1, legal and aligned: latch we, size, addr[1:0], rd_addr, be and wdata; go to REQ.
- REQ: bus_req_o=1. bus_we/addr/be/wdata stay stable until bus_gnt_i=1.
  - gnt=1, rvalid=0: go to WAIT; drop bus_req_o.
  - gnt=1 and rvalid=1 in the same cycle (zero-wait memory): complete immediately and go to IDLE.
- WAIT: counter increments every cycle.
  - On rvalid: complete and go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES without rvalid: exc_o=1, cause=2, go to IDLE, no writeback.
- Completion of a load:
  - Next cycle: rd_wr_en_o=1 for one cycle, with rd_addr_o and rd_data_o = formatted data.
  - rd_wr_en_o is suppressed when rd_addr==0.
- Completion of a store: no writeback.
- Load formatting: byte lane is selected by addr[1:0], halfword by addr[1].
  - LB and LH sign-extend to 32 bits.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Store encoding:
  - SB: be=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<addr[1:0]; wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111; wdata unchanged.
- hold_flag_o (combinational): 1 when (state==IDLE && req_i && legal && aligned) || state!=IDLE. It falls in the cycle after completion.
- bus_gnt_i and bus_rvalid_i are ignored in IDLE.
- req_i is ignored while state!=IDLE. Ex holds its request under hold_flag_o; it is never re-accepted.
- The exception pulse and the writeback pulse are mutually exclusive.

Decomposition:
- Shared package mem_access_pkg holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - state encoding (IDLE, REQ, WAIT)
  - exception cause codes (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_TIMEOUT, CAUSE_ILLEGAL)
- One combinational sub-module, mem_load_align: inputs rdata, offset[1:0] and size; output is the extended 32-bit word.
- Store lane encoding stays inline.

Test Plan:
- Zero-wait LW: addr=0x100, rd=5; gnt and rvalid in the REQ cycle with rdata=0xDEADBEEF. Required: bus_addr=0x100, be=1111; one cycle later rd_wr_en=1, rd=5, data=0xDEADBEEF; hold high for exactly 2 cycles.
- LB/LBU: addr=0x103, rdata=0x80FF_FF7F, 3-cycle rvalid delay. Required: LB gives 0xFFFFFF80; LBU gives 0x00000080; hold held through the whole wait.
- SH: addr=0x206, wdata=0x1234ABCD. Required: bus_addr=0x204, be=1100, bus_wdata=0xABCDABCD, we=1; no rd_wr_en after rvalid.
- Misaligned LW: addr=0x102. Required: no bus_req; exc_o=1 and cause=1 for one cycle.
- Bus timeout: gnt given, rvalid never arrives. Required: exc_o=1 and cause=2 after 16 WAIT cycles; return to IDLE; no writeback.
- Reset in WAIT: rst=0 while waiting, then rvalid arrives. Required: all outputs 0, rvalid ignored, next req_i accepted normally. Also: LW with rd=0 produces no rd_wr_en.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants for the load/store stage
package mem_access_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects and extends the loaded byte/halfword/word
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        case (offset)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            LB:      data = {{24{byte_v[7]}}, byte_v};
            LH:      data = {{16{half_v[15]}}, half_v};
            LBU:     data = {24'h0, byte_v};
            LHU:     data = {16'h0, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store stage driving a req/gnt/rvalid data bus
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_addr_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wr_en_o,
    output logic        hold_flag_o,
    output logic        exc_o,
    output logic [1:0]  exc_cause_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state;
    logic [TO_W-1:0] to_cnt;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;

    logic        size_illegal;
    logic        misaligned;
    logic        complete;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] load_data;

    always_comb begin
        if (we_i) begin
            size_illegal = (size_i > SW);
        end else begin
            size_illegal = (size_i == 3'd3) || (size_i == 3'd6) || (size_i == 3'd7);
        end
        misaligned = ((size_i[1:0] == 2'd1) && addr_i[0]) ||
                     ((size_i[1:0] == 2'd2) && (addr_i[1:0] != 2'd0));

        // Lane encoding also used for loads so bus_be_o reflects the bytes read.
        case (size_i[1:0])
            2'd0: begin
                be_calc    = 4'b0001 << addr_i[1:0];
                wdata_calc = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                be_calc    = 4'b0011 << addr_i[1:0];
                wdata_calc = {2{wdata_i[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata_i;
            end
        endcase

        complete = ((state == REQ) && bus_gnt_i && bus_rvalid_i) ||
                   ((state == WAIT) && bus_rvalid_i);

        hold_flag_o = rst && (((state == IDLE) && req_i && !size_illegal && !misaligned) ||
                              (state != IDLE));
    end

    mem_load_align u_load_align (
        .rdata  (bus_rdata_i),
        .offset (off_q),
        .size   (size_q),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            to_cnt      <= '0;
            we_q        <= 1'b0;
            size_q      <= 3'd0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_be_o    <= 4'h0;
            bus_wdata_o <= 32'h0;
            rd_addr_o   <= 5'd0;
            rd_data_o   <= 32'h0;
            rd_wr_en_o  <= 1'b0;
            exc_o       <= 1'b0;
            exc_cause_o <= CAUSE_NONE;
        end else begin
            rd_wr_en_o  <= 1'b0;
            exc_o       <= 1'b0;
            exc_cause_o <= CAUSE_NONE;

            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (size_illegal) begin
                            exc_o       <= 1'b1;
                            exc_cause_o <= CAUSE_ILLEGAL;
                        end else if (misaligned) begin
                            exc_o       <= 1'b1;
                            exc_cause_o <= CAUSE_MISALIGN;
                        end else begin
                            we_q        <= we_i;
                            size_q      <= size_i;
                            off_q       <= addr_i[1:0];
                            rd_q        <= rd_addr_i;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= we_i;
                            bus_addr_o  <= {addr_i[31:2], 2'b00};
                            bus_be_o    <= be_calc;
                            bus_wdata_o <= wdata_calc;
                            state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        to_cnt    <= '0;
                        state     <= bus_rvalid_i ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        state <= IDLE;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        exc_o       <= 1'b1;
                        exc_cause_o <= CAUSE_TIMEOUT;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Stores and writes to x0 complete silently.
            if (complete && !we_q) begin
                rd_addr_o  <= rd_q;
                rd_data_o  <= load_data;
                rd_wr_en_o <= (rd_q != 5'd0);
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for the load/store stage
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  size_i = 3'd0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [4:0]  rd_addr_i = 5'd0;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'h0;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wr_en_o;
    logic        hold_flag_o;
    logic        exc_o;
    logic [1:0]  exc_cause_o;

    typedef struct {
        logic        is_exc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  cause;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [111:0] all_out;

    assign all_out = {bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, rd_addr_o,
                      rd_data_o, rd_wr_en_o, hold_flag_o, exc_o, exc_cause_o};

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .we_i         (we_i),
        .size_i       (size_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rd_addr_i    (rd_addr_i),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .rd_wr_en_o   (rd_wr_en_o),
        .hold_flag_o  (hold_flag_o),
        .exc_o        (exc_o),
        .exc_cause_o  (exc_cause_o)
    );

    task automatic drive_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] w, input logic [4:0] rd);
        req_i = 1'b1; we_i = we; size_i = sz; addr_i = a; wdata_i = w; rd_addr_i = rd;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (all_out !== '0) begin miscompares++; $display("FAIL reset_outputs got %h exp 0", all_out); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw_zero_wait;
        exp_t e;
        drive_req(1'b0, LW, 32'h100, 32'h0, 5'd5);
        #1;
        vectors++;
        if (hold_flag_o !== 1'b1) begin miscompares++; $display("FAIL lw_hold_accept got %b exp 1", hold_flag_o); end
        exp_q.push_back('{1'b0, 5'd5, 32'hDEADBEEF, CAUSE_NONE});
        @(negedge clk);
        req_i = 1'b0;
        vectors++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, hold_flag_o} !== {1'b1, 1'b0, 32'h100, 4'b1111, 1'b1}) begin
            miscompares++;
            $display("FAIL lw_bus got req=%b we=%b addr=%h be=%b hold=%b exp 1 0 00000100 1111 1",
                     bus_req_o, bus_we_o, bus_addr_o, bus_be_o, hold_flag_o);
        end
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL lw_sb_empty got pulse exp queued entry"); end
        else begin
            e = exp_q.pop_front();
            if ({rd_wr_en_o, exc_o, rd_addr_o, rd_data_o} !== {1'b1, 1'b0, e.rd, e.data}) begin
                miscompares++;
                $display("FAIL lw_wb got en=%b exc=%b rd=%0d data=%h exp 1 0 %0d %h",
                         rd_wr_en_o, exc_o, rd_addr_o, rd_data_o, e.rd, e.data);
            end
        end
        vectors++;
        if ({hold_flag_o, bus_req_o} !== 2'b00) begin miscompares++; $display("FAIL lw_hold_fall got %b exp 00", {hold_flag_o, bus_req_o}); end
        @(negedge clk);
        vectors++;
        if (rd_wr_en_o !== 1'b0) begin miscompares++; $display("FAIL lw_wb_pulse got %b exp 0", rd_wr_en_o); end
    endtask

    task automatic test_lb_lbu;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            drive_req(1'b0, (k == 0) ? LB : LBU, 32'h103, 32'h0, 5'd7);
            exp_q.push_back('{1'b0, 5'd7, (k == 0) ? 32'hFFFFFF80 : 32'h00000080, CAUSE_NONE});
            @(negedge clk);
            req_i = 1'b0;
            vectors++;
            if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h100}) begin
                miscompares++; $display("FAIL lb_bus got req=%b addr=%h exp 1 00000100", bus_req_o, bus_addr_o);
            end
            bus_gnt_i = 1'b1;
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                bus_gnt_i = 1'b0;
                vectors++;
                if ({hold_flag_o, bus_req_o, rd_wr_en_o} !== 3'b100) begin
                    miscompares++; $display("FAIL lb_wait%0d got hold/req/wb=%b exp 100", w, {hold_flag_o, bus_req_o, rd_wr_en_o});
                end
                bus_rvalid_i = (w == 2);
                bus_rdata_i = 32'h80FFFF7F;
            end
            @(negedge clk);
            bus_rvalid_i = 1'b0;
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL lb_sb_empty got pulse exp queued entry"); end
            else begin
                e = exp_q.pop_front();
                if ({rd_wr_en_o, exc_o, rd_addr_o, rd_data_o} !== {1'b1, 1'b0, e.rd, e.data}) begin
                    miscompares++;
                    $display("FAIL lb_wb%0d got en=%b exc=%b rd=%0d data=%h exp 1 0 %0d %h",
                             k, rd_wr_en_o, exc_o, rd_addr_o, rd_data_o, e.rd, e.data);
                end
            end
        end
    endtask

    task automatic test_store;
        logic [2:0]  sz [3] = '{SH, SB, SW};
        logic [31:0] ad [3] = '{32'h206, 32'h301, 32'h408};
        logic [31:0] wd [3] = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D};
        logic [31:0] ea [3] = '{32'h204, 32'h300, 32'h408};
        logic [3:0]  eb [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ew [3] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'hCAFEF00D};
        for (int t = 0; t < 3; t++) begin
            drive_req(1'b1, sz[t], ad[t], wd[t], 5'd11);
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                req_i = 1'b0;
                vectors++;
                if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o} !== {1'b1, 1'b1, ea[t], eb[t], ew[t]}) begin
                    miscompares++;
                    $display("FAIL st%0d_bus_c%0d got req=%b we=%b addr=%h be=%b wdata=%h exp 1 1 %h %b %h",
                             t, c, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, ea[t], eb[t], ew[t]);
                end
                bus_gnt_i = (c == 1);
            end
            @(negedge clk);
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1;
            vectors++;
            if ({bus_req_o, hold_flag_o} !== 2'b01) begin miscompares++; $display("FAIL st%0d_wait got req/hold=%b exp 01", t, {bus_req_o, hold_flag_o}); end
            @(negedge clk);
            bus_rvalid_i = 1'b0;
            vectors++;
            if ({rd_wr_en_o, exc_o, hold_flag_o} !== 3'b000) begin miscompares++; $display("FAIL st%0d_done got wb/exc/hold=%b exp 000", t, {rd_wr_en_o, exc_o, hold_flag_o}); end
            @(negedge clk);
            vectors++;
            if (rd_wr_en_o !== 1'b0) begin miscompares++; $display("FAIL st%0d_nowb got %b exp 0", t, rd_wr_en_o); end
        end
    endtask

    task automatic test_exceptions;
        exp_t e;
        logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  sz [4] = '{LW, LH, 3'd3, 3'd4};
        logic [31:0] ad [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
        logic [1:0]  ca [4] = '{CAUSE_MISALIGN, CAUSE_MISALIGN, CAUSE_ILLEGAL, CAUSE_ILLEGAL};
        for (int t = 0; t < 4; t++) begin
            drive_req(we[t], sz[t], ad[t], 32'h0, 5'd6);
            #1;
            vectors++;
            if (hold_flag_o !== 1'b0) begin miscompares++; $display("FAIL exc%0d_hold got %b exp 0", t, hold_flag_o); end
            exp_q.push_back('{1'b1, 5'd0, 32'h0, ca[t]});
            @(negedge clk);
            req_i = 1'b0;
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL exc%0d_sb_empty got pulse exp queued entry", t); end
            else begin
                e = exp_q.pop_front();
                if ({bus_req_o, rd_wr_en_o, exc_o, exc_cause_o} !== {1'b0, 1'b0, 1'b1, e.cause}) begin
                    miscompares++;
                    $display("FAIL exc%0d got req=%b wb=%b exc=%b cause=%0d exp 0 0 1 %0d",
                             t, bus_req_o, rd_wr_en_o, exc_o, exc_cause_o, e.cause);
                end
            end
            @(negedge clk);
            vectors++;
            if ({exc_o, exc_cause_o, bus_req_o} !== 4'b0000) begin miscompares++; $display("FAIL exc%0d_pulse got %b exp 0000", t, {exc_o, exc_cause_o, bus_req_o}); end
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        drive_req(1'b0, LW, 32'h40, 32'h0, 5'd3);
        exp_q.push_back('{1'b1, 5'd0, 32'h0, CAUSE_TIMEOUT});
        @(negedge clk);
        req_i = 1'b0; bus_gnt_i = 1'b1;
        for (int w = 0; w < 16; w++) begin
            @(negedge clk);
            bus_gnt_i = 1'b0;
            vectors++;
            if ({hold_flag_o, exc_o} !== 2'b10) begin miscompares++; $display("FAIL to_wait%0d got hold/exc=%b exp 10", w, {hold_flag_o, exc_o}); end
        end
        @(negedge clk);
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL to_sb_empty got pulse exp queued entry"); end
        else begin
            e = exp_q.pop_front();
            if ({exc_o, exc_cause_o, rd_wr_en_o, hold_flag_o} !== {1'b1, e.cause, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL to_exc got exc=%b cause=%0d wb=%b hold=%b exp 1 %0d 0 0",
                         exc_o, exc_cause_o, rd_wr_en_o, hold_flag_o, e.cause);
            end
        end
        @(negedge clk);
        vectors++;
        if ({exc_o, rd_wr_en_o} !== 2'b00) begin miscompares++; $display("FAIL to_after got exc/wb=%b exp 00", {exc_o, rd_wr_en_o}); end
    endtask

    task automatic test_reset_in_wait;
        exp_t e;
        drive_req(1'b0, LW, 32'h80, 32'h0, 5'd4);
        @(negedge clk);
        req_i = 1'b0; bus_gnt_i = 1'b1;
        @(negedge clk);
        bus_gnt_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (all_out !== '0) begin miscompares++; $display("FAIL rstw_outputs got %h exp 0", all_out); end
        rst = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11111111;
        @(negedge clk);
        bus_rvalid_i = 1'b0;
        vectors++;
        if (all_out !== '0) begin miscompares++; $display("FAIL rstw_rvalid_ignored got %h exp 0", all_out); end
        drive_req(1'b0, LW, 32'h84, 32'h0, 5'd9);
        exp_q.push_back('{1'b0, 5'd9, 32'h55AA33CC, CAUSE_NONE});
        @(negedge clk);
        req_i = 1'b0;
        vectors++;
        if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h84}) begin miscompares++; $display("FAIL rstw_reaccept got req=%b addr=%h exp 1 00000084", bus_req_o, bus_addr_o); end
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55AA33CC;
        @(negedge clk);
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL rstw_sb_empty got pulse exp queued entry"); end
        else begin
            e = exp_q.pop_front();
            if ({rd_wr_en_o, rd_addr_o, rd_data_o} !== {1'b1, e.rd, e.data}) begin
                miscompares++;
                $display("FAIL rstw_wb got en=%b rd=%0d data=%h exp 1 %0d %h", rd_wr_en_o, rd_addr_o, rd_data_o, e.rd, e.data);
            end
        end
    endtask

    task automatic test_rd0;
        drive_req(1'b0, LW, 32'h10, 32'h0, 5'd0);
        @(negedge clk);
        req_i = 1'b0; bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        vectors++;
        if ({rd_wr_en_o, exc_o, hold_flag_o} !== 3'b000) begin miscompares++; $display("FAIL rd0_nowb got wb/exc/hold=%b exp 000", {rd_wr_en_o, exc_o, hold_flag_o}); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [2:0]  sz [2] = '{LH, LHU};
        logic [31:0] ad [2] = '{32'h102, 32'h100};
        logic [31:0] rdv[2] = '{32'h80011234, 32'h7FFF9234};
        logic [31:0] ex [2] = '{32'hFFFF8001, 32'h00009234};
        drive_req(1'b0, sz[0], ad[0], 32'h0, 5'd12);
        exp_q.push_back('{1'b0, 5'd12, ex[0], CAUSE_NONE});
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            req_i = 1'b0; bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = rdv[t];
            @(negedge clk);
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b%0d_sb_empty got pulse exp queued entry", t); end
            else begin
                e = exp_q.pop_front();
                if ({rd_wr_en_o, rd_addr_o, rd_data_o} !== {1'b1, e.rd, e.data}) begin
                    miscompares++;
                    $display("FAIL b2b%0d_wb got en=%b rd=%0d data=%h exp 1 %0d %h", t, rd_wr_en_o, rd_addr_o, rd_data_o, e.rd, e.data);
                end
            end
            if (t == 0) begin
                drive_req(1'b0, sz[1], ad[1], 32'h0, 5'd13);
                exp_q.push_back('{1'b0, 5'd13, ex[1], CAUSE_NONE});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_lb_lbu();
        test_store();
        test_exceptions();
        test_timeout();
        test_reset_in_wait();
        test_rd0();
        test_back_to_back();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
